// File: rtl/barrel_shift_pkg.sv
// Shared constants and types for the barrel shift arbiter slice.
// Holds the shifter widths, the output slot state type and a rotate-right reference.
package barrel_shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Reference rotate-right: the low half of {d,d} shifted right by a.
    function automatic logic [DATA_W-1:0] rotr(
        input logic [DATA_W-1:0] d,
        input logic [AMT_W-1:0]  a
    );
        logic [2*DATA_W-1:0] w_dbl;
        w_dbl = {d, d} >> a;
        return w_dbl[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/barrel_shifter_32bit.sv
// Combinational 32-bit rotate-right barrel shifter, five log2 stages.
// Ports: i_data operand, i_amt rotate amount (0..31), o_data rotated result.
module barrel_shifter_32bit (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_amt,
    output logic [31:0] o_data
);

    logic [5:0][31:0] w_stage;

    assign w_stage[0] = i_data;

    for (genvar s = 0; s < 5; s++) begin : g_stage
        localparam int SH = 1 << s;
        assign w_stage[s+1] = i_amt[s]
            ? {w_stage[s][SH-1:0], w_stage[s][31:SH]}
            : w_stage[s];
    end

    assign o_data = w_stage[5];

endmodule

// File: rtl/bs_rr_arbiter.sv
// Round-robin priority picker: first valid requester at or after i_rr_ptr, wrapping.
// Ports: i_req_valid, i_rr_ptr, i_enable in; o_grant one-hot, o_grant_idx out.
module bs_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]  i_rr_ptr,
    input  logic             i_enable,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_idx
);

    logic            w_found;
    logic [ID_W-1:0] w_j;
    int              w_sum;

    // o_grant_idx is driven even when disabled so it can steer the
    // operand mux unconditionally; only o_grant is gated.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_j         = '0;
        w_sum       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = int'(i_rr_ptr) + k;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
            w_j = ID_W'(w_sum);
            if (!w_found && i_req_valid[w_j]) begin
                w_found     = 1'b1;
                o_grant_idx = w_j;
            end
        end
        if (w_found && i_enable) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Shares one rotate-right shifter among N_REQ valid/ready requesters, round-robin,
// with a single registered output slot tagged by requester id.
// Ports: clk, rst_n; req_valid/req_ready/req_data/req_amt per requester;
// rsp_valid/rsp_ready/rsp_data/rsp_id result slot; op_count accepted-op counter.
module barrel_shift_arbiter
    import barrel_shift_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0][AMT_W-1:0]  req_amt,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [ID_W-1:0]              rsp_id,
    output logic [CNT_W-1:0]             op_count
);

    slot_state_t       r_state;
    slot_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_rsp_data;
    logic [ID_W-1:0]   r_rsp_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_op_count;

    logic              w_slot_free;
    logic              w_enable;
    logic              w_accept;
    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_gnt_idx;
    logic [ID_W-1:0]   w_rr_nxt;
    logic [DATA_W-1:0] w_sh_data;
    logic [AMT_W-1:0]  w_sh_amt;
    logic [DATA_W-1:0] w_rot;

    assign rsp_valid   = (r_state == SLOT_FULL);
    assign w_slot_free = !rsp_valid || rsp_ready;
    // rst_n gates grants so req_ready is low throughout reset.
    assign w_enable    = w_slot_free && rst_n;

    bs_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .i_enable    (w_enable),
        .o_grant     (w_grant),
        .o_grant_idx (w_gnt_idx)
    );

    assign req_ready = w_grant;
    assign w_accept  = |w_grant;

    assign w_sh_data = req_data[w_gnt_idx];
    assign w_sh_amt  = req_amt[w_gnt_idx];

    barrel_shifter_32bit u_shifter (
        .i_data (w_sh_data),
        .i_amt  (w_sh_amt),
        .o_data (w_rot)
    );

    assign w_rr_nxt = (w_gnt_idx == ID_W'(N_REQ - 1))
        ? '0
        : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A drain and a new accept in the same cycle keep the slot full.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SLOT_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (rsp_ready && !w_accept) begin
                    w_state_nxt = SLOT_EMPTY;
                end
            end
            default: w_state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_rr_ptr   <= '0;
            r_op_count <= '0;
        end else if (w_accept) begin
            r_rsp_data <= w_rot;
            r_rsp_id   <= w_gnt_idx;
            r_rr_ptr   <= w_rr_nxt;
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_rsp_id;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter: vector table plus hand sequences,
// with a result queue popped whenever the output slot drains.
module tb_barrel_shift_arbiter;
    import barrel_shift_pkg::*;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 4;

    logic                         clk;
    logic                         rst_n;
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0][DATA_W-1:0] req_data;
    logic [N_REQ-1:0][AMT_W-1:0]  req_amt;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [DATA_W-1:0]            rsp_data;
    logic [ID_W-1:0]              rsp_id;
    logic [CNT_W-1:0]             op_count;

    barrel_shift_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [19:0] amt;
        logic        acc;
        logic [1:0]  id;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    vec_t             vt[16];
    exp_t             sb[$];
    exp_t             e;
    int               n_pass;
    int               n_tot;
    logic             mon_en;
    logic [CNT_W-1:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d,
                                input logic [19:0] a, input logic acc,
                                input logic [1:0] id, input logic [31:0] x);
        vec_t r;
        r.valid = v;
        r.data  = d;
        r.amt   = a;
        r.acc   = acc;
        r.id    = id;
        r.exp   = x;
        return r;
    endfunction

    task automatic push(input logic [1:0] id, input logic [31:0] d);
        exp_t t;
        t.id   = id;
        t.data = d;
        sb.push_back(t);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    // Result monitor: a result leaves the slot on an edge where valid && ready.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_tot++;
                    $display("FAIL rsp_unexpected: got id %0d data %h expected none",
                             rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_tot   = 0;
        mon_en  = 1'b0;
        exp_cnt = '0;

        vt[0]  = mk(4'b0001, 32'h3, {5'd0, 5'd0, 5'd0, 5'd1}, 1'b1, 2'd0, 32'h80000001);
        vt[1]  = mk(4'b1000, 32'h3, {5'd31, 5'd0, 5'd0, 5'd0}, 1'b1, 2'd3, 32'h00000006);
        vt[2]  = mk(4'b1111, 32'h3, {5'd31, 5'd30, 5'd2, 5'd0}, 1'b1, 2'd0, 32'h00000003);
        vt[3]  = mk(4'b1111, 32'h3, {5'd31, 5'd30, 5'd2, 5'd0}, 1'b1, 2'd1, 32'hC0000000);
        vt[4]  = mk(4'b1111, 32'h3, {5'd31, 5'd30, 5'd2, 5'd0}, 1'b1, 2'd2, 32'h0000000C);
        vt[5]  = mk(4'b1111, 32'h3, {5'd31, 5'd30, 5'd2, 5'd0}, 1'b1, 2'd3, 32'h00000006);
        for (int k = 6; k < 14; k++) begin
            vt[k] = mk(4'b0101, 32'h3, {4{5'd4}}, 1'b1,
                       (k % 2 == 0) ? 2'd0 : 2'd2, 32'h30000000);
        end
        vt[14] = mk(4'b0000, 32'h3, {4{5'd4}}, 1'b0, 2'd0, 32'h0);
        vt[15] = mk(4'b0011, 32'h12345678, {5'd0, 5'd0, 5'd0, 5'd16}, 1'b1, 2'd0, 32'h56781234);

        // Reset with every requester asking.
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_amt   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        // Withdraw before the edge: no grant may be consumed.
        req_valid = '0;
        mon_en    = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req_valid = vt[i].valid;
            req_data  = {4{vt[i].data}};
            req_amt   = vt[i].amt;
            rsp_ready = 1'b1;
            #1;
            chk("op_count", 32'(op_count), 32'(exp_cnt));
            chk("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
            chk("req_ready", 32'(req_ready),
                vt[i].acc ? 32'(4'b0001 << vt[i].id) : 32'h0);
            if (vt[i].acc) begin
                push(vt[i].id, vt[i].exp);
            end
        end
        @(negedge clk);
        req_valid = '0;

        // Backpressure on requester 1.
        @(negedge clk);
        req_valid   = 4'b0010;
        req_data[1] = 32'hA5A50001;
        req_amt[1]  = 5'd8;
        #1;
        chk("bp_req_ready0", 32'(req_ready), 32'h2);
        push(2'd1, rotr(32'hA5A50001, 5'd8));
        @(negedge clk);
        rsp_ready   = 1'b0;
        req_data[1] = 32'h000000FF;
        req_amt[1]  = 5'd4;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_data", rsp_data, 32'h01A5A500);
            chk("bp_rsp_id", 32'(rsp_id), 32'h1);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_op_count", 32'(op_count), 32'(exp_cnt));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h2);
        push(2'd1, rotr(32'h000000FF, 5'd4));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("b2b_rsp_data", rsp_data, 32'hF000000F);
        chk("wrap_op_count", 32'(op_count), 32'(exp_cnt));
        @(negedge clk);
        #1;
        chk("drain_rsp_valid", 32'(rsp_valid), 32'h0);

        // Reset while a result is stuck behind backpressure.
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = {4{32'h3}};
        req_amt   = {4{5'd4}};
        rsp_ready = 1'b1;
        #1;
        chk("mid_req_ready", 32'(req_ready), 32'h4);
        push(2'd2, rotr(32'h3, 5'd4));
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = '1;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("mid_bp_ready", 32'(req_ready), 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("async_op_count", 32'(op_count), 32'h0);
        chk("async_req_ready", 32'(req_ready), 32'h0);
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("restart_grant", 32'(req_ready), 32'h1);
        push(2'd0, rotr(32'h3, 5'd4));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("restart_count", 32'(op_count), 32'(exp_cnt));
        @(negedge clk);
        #3;
        chk("final_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
